// File: rtl/sm_addsub_pipe.sv
// Two-stage sign-magnitude adder/subtractor with valid/ready handshake.
// S1 holds normalised operands and the magnitude compare; S2 holds the result.
module sm_addsub_pipe #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   input  logic                  op,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] sum,
   output logic                  overflow
);

   localparam int MW = DATA_WIDTH - 1;

   logic          s1_valid_q, s1_valid_d;
   logic [MW-1:0] s1_amag_q, s1_amag_d;
   logic [MW-1:0] s1_bmag_q, s1_bmag_d;
   logic          s1_asign_q, s1_asign_d;
   logic          s1_bsign_q, s1_bsign_d;
   logic          s1_age_q, s1_age_d;

   logic                  s2_valid_q, s2_valid_d;
   logic [DATA_WIDTH-1:0] s2_sum_q, s2_sum_d;
   logic                  s2_ovf_q, s2_ovf_d;

   logic          s1_adv, s2_adv;
   logic [MW:0]   mag_add;
   logic [MW-1:0] mag_res;
   logic          sign_raw, ovf_res;

   always_comb begin
      s2_adv = !s2_valid_q || out_ready;
      s1_adv = !s1_valid_q || s2_adv;
   end

   // Negative zero is folded to +0 here so S2 never sees a signed zero operand.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_amag_d  = s1_amag_q;
      s1_bmag_d  = s1_bmag_q;
      s1_asign_d = s1_asign_q;
      s1_bsign_d = s1_bsign_q;
      s1_age_d   = s1_age_q;
      if (s1_adv) begin
         s1_valid_d = in_valid;
         s1_amag_d  = a[MW-1:0];
         s1_bmag_d  = b[MW-1:0];
         s1_asign_d = a[MW] & (|a[MW-1:0]);
         s1_bsign_d = (b[MW] ^ op) & (|b[MW-1:0]);
         s1_age_d   = (a[MW-1:0] >= b[MW-1:0]);
      end
   end

   always_comb begin
      mag_add  = {1'b0, s1_amag_q} + {1'b0, s1_bmag_q};
      mag_res  = '0;
      sign_raw = 1'b0;
      ovf_res  = 1'b0;
      if (s1_asign_q == s1_bsign_q) begin
         ovf_res  = mag_add[MW];
         mag_res  = mag_add[MW] ? '1 : mag_add[MW-1:0];
         sign_raw = s1_asign_q;
      end else if (s1_age_q) begin
         mag_res  = s1_amag_q - s1_bmag_q;
         sign_raw = s1_asign_q;
      end else begin
         mag_res  = s1_bmag_q - s1_amag_q;
         sign_raw = s1_bsign_q;
      end
   end

   always_comb begin
      s2_valid_d = s2_valid_q;
      s2_sum_d   = s2_sum_q;
      s2_ovf_d   = s2_ovf_q;
      if (s2_adv) begin
         s2_valid_d = s1_valid_q;
         s2_sum_d   = {sign_raw & (|mag_res), mag_res};
         s2_ovf_d   = ovf_res;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s1_amag_q  <= '0;
         s1_bmag_q  <= '0;
         s1_asign_q <= 1'b0;
         s1_bsign_q <= 1'b0;
         s1_age_q   <= 1'b0;
         s2_valid_q <= 1'b0;
         s2_sum_q   <= '0;
         s2_ovf_q   <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_amag_q  <= s1_amag_d;
         s1_bmag_q  <= s1_bmag_d;
         s1_asign_q <= s1_asign_d;
         s1_bsign_q <= s1_bsign_d;
         s1_age_q   <= s1_age_d;
         s2_valid_q <= s2_valid_d;
         s2_sum_q   <= s2_sum_d;
         s2_ovf_q   <= s2_ovf_d;
      end
   end

   assign in_ready  = s1_adv;
   assign out_valid = s2_valid_q;
   assign sum       = s2_sum_q;
   assign overflow  = s2_ovf_q;

endmodule

// File: doc/sm_addsub_pipe.md
SM_ADDSUB_PIPE -- requirements
Module: sm_addsub_pipe

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the total operand/result width: 1 sign bit (MSB) plus a DATA_WIDTH-1 bit magnitude; legal range 3..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the upstream operand pair is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts an operand pair this cycle.
REQ-006 The block SHALL have port a, input, DATA_WIDTH bits: sign-magnitude operand A.
REQ-007 The block SHALL have port b, input, DATA_WIDTH bits: sign-magnitude operand B.
REQ-008 The block SHALL have port op, input, 1 bit: 0 = A+B, 1 = A-B.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-011 The block SHALL have port sum, output, DATA_WIDTH bits: sign-magnitude result.
REQ-012 The block SHALL have port overflow, output, 1 bit: result magnitude saturated; qualified by out_valid.

Function
REQ-013 A transfer SHALL occur on a rising edge where valid and ready are both high, on either the input or the output side.
REQ-014 The block SHALL be a 2-stage pipeline: S1 registers operands, effective B sign (b[MSB] XOR op), and magnitude compare (A >= B); S2 registers sum/overflow.
REQ-015 With out_ready held high, a result SHALL appear on out_valid exactly 2 cycles after its input transfer, at a throughput of 1 result per cycle.
REQ-016 S2 SHALL advance when out_valid is low or out_ready is high; S1 SHALL advance when S1 is empty or S2 advances.
REQ-017 in_ready SHALL equal (S1 empty) OR (S2 advancing); in_ready SHALL NOT depend combinationally on in_valid.
REQ-018 While out_valid is high and out_ready is low, sum and overflow SHALL hold stable.
REQ-019 Results SHALL leave the block in input order, with no loss or duplication under any out_ready pattern.
REQ-020 For equal effective signs: magnitude = |A|+|B| computed at DATA_WIDTH bits, sign = the common sign.
REQ-021 If that magnitude sum carries out of DATA_WIDTH-1 bits, overflow SHALL be 1 and the magnitude SHALL saturate to all ones, keeping the sign.
REQ-022 For differing effective signs: magnitude = larger minus smaller, sign = sign of the larger-magnitude operand, overflow = 0.
REQ-023 If the magnitudes are equal and the effective signs differ, the result SHALL be +0 (all zeros).
REQ-024 Input negative zero (sign 1, magnitude 0) SHALL be treated as zero, and the block SHALL never output negative zero; any zero-magnitude result has sign 0.
REQ-025 When the pipeline is empty and in_valid is low, out_valid SHALL be 0.

Reset
REQ-026 While reset is high at a clock edge: S1/S2 valid flags, out_valid, sum, and overflow SHALL clear to 0, and in_ready SHALL be 1 from the cycle after reset.
REQ-027 An input transfer coinciding with reset SHALL be discarded.
REQ-028 Reset mid-operation SHALL drop all in-flight results, with no out_valid pulse afterwards for them.

Verification (DATA_WIDTH=8, out_ready=1 unless stated)
REQ-029 Mixed signs: a=0x05, b=0x83, op=0 -> 2 cycles later sum=0x02, overflow=0.
REQ-030 Subtract and sign flip: a=0x03, b=0x05, op=1 -> sum=0x82; then a=0x85, b=0x05, op=0 -> sum=0x00 (not 0x80).
REQ-031 Saturation: a=0x64, b=0x64, op=0 -> sum=0x7F, overflow=1; a=0xE4, b=0x64, op=1 -> sum=0xFF, overflow=1.
REQ-032 Backpressure: stream 6 back-to-back pairs while holding out_ready=0 for cycles 3-6 -> in_ready drops after 2 pairs are held, sum holds stable, and all 6 results emerge in order with none lost.
REQ-033 Negative-zero inputs: a=0x80, b=0x80, op=0 -> sum=0x00; a=0x80, b=0x00, op=1 -> sum=0x00.
REQ-034 Reset mid-stream: assert reset for 1 cycle while 2 results are in flight -> out_valid=0 the next cycle, no stale result appears, and in_ready=1 after reset.
